// File: rtl/mem_ctrl_if.sv
// CPU-side request/response bundle for mem_ctrl.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_write           : 1 = store, 0 = load
//   req_size            : 0 byte, 1 half, 2 word, 3 treated as word
//   req_signed          : sign-extend load result
//   req_addr/req_wdata  : byte address (any alignment), little-endian store data
//   resp_valid          : one-cycle completion pulse (loads and stores)
//   resp_rdata          : extended load data, 0 for stores
interface mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns byte/half/word CPU loads and stores
// into a sequence of single-byte accesses on a RAM/HCI bus, with I/O write
// throttling against the HCI output FIFO and a global rdy freeze.
//   clk, rst_n      : clock, asynchronous active-low reset
//   rdy             : global run enable, low freezes all state
//   bus             : CPU request/response (mem_ctrl_if.slave)
//   mem_a           : byte address to the bus (0 when not issuing)
//   mem_wr          : byte write strobe
//   mem_dout        : byte written
//   mem_din         : byte read, valid one rdy-high cycle after its address
//   io_buffer_full  : HCI output FIFO full
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    mem_ctrl_if.slave   bus,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [23:0] rbuf_q;     // the last load byte is taken straight from mem_din
    logic [2:0]  cnt_q;
    logic [2:0]  nbytes_q;
    logic        signed_q;
    logic        write_q;
    logic        io_prev_q;  // an I/O write byte issued on the previous active cycle

    logic accept, last, is_io, io_hold, issue_rd, issue_wr;

    assign accept   = (state == IDLE) && rdy && bus.req_valid;
    assign last     = (cnt_q == nbytes_q - 3'd1);
    assign is_io    = (addr_q[17:16] == IO_HI);
    // The full flag lags one cycle behind a write, so back-to-back I/O bytes
    // must be spaced by one cycle even when full still reads low.
    assign io_hold  = is_io && (io_buffer_full || io_prev_q);
    assign issue_rd = (state == READ) && rdy;
    assign issue_wr = (state == WRITE) && rdy && !io_hold;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)             state_nx = bus.req_write ? WRITE : READ;
            READ:    if (issue_rd && last)   state_nx = FINISH;
            WRITE:   if (issue_wr && last)   state_nx = FINISH;
            FINISH:  if (rdy)                state_nx = IDLE;
            default:                         state_nx = IDLE;
        endcase
    end

    // Request latch, address/byte counters and load byte capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            cnt_q    <= '0;
            nbytes_q <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
        end else if (accept) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rbuf_q   <= '0;
            cnt_q    <= '0;
            signed_q <= bus.req_signed;
            write_q  <= bus.req_write;
            case (bus.req_size)
                2'd0:    nbytes_q <= 3'd1;
                2'd1:    nbytes_q <= 3'd2;
                default: nbytes_q <= 3'd4;
            endcase
        end else begin
            // mem_din holds the byte issued on the previous active cycle
            if (issue_rd) begin
                case (cnt_q)
                    3'd1:    rbuf_q[7:0]   <= mem_din;
                    3'd2:    rbuf_q[15:8]  <= mem_din;
                    3'd3:    rbuf_q[23:16] <= mem_din;
                    default: ;
                endcase
            end
            if (issue_rd || issue_wr) begin
                addr_q <= addr_q + 32'd1;
                cnt_q  <= cnt_q + 3'd1;
            end
            if (issue_wr) wdata_q <= wdata_q >> 8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   io_prev_q <= 1'b0;
        else if (rdy) io_prev_q <= issue_wr && is_io;
    end

    // Outputs
    always_comb begin
        mem_a          = '0;
        mem_wr         = 1'b0;
        mem_dout       = '0;
        bus.req_ready  = (state == IDLE) && rdy;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        case (state)
            READ: mem_a = addr_q;
            WRITE: begin
                if (!io_hold) begin
                    mem_a    = addr_q;
                    mem_dout = wdata_q[7:0];
                    mem_wr   = rdy;
                end
            end
            FINISH: begin
                bus.resp_valid = rdy;
                if (rdy && !write_q) begin
                    case (nbytes_q)
                        3'd1:    bus.resp_rdata = {{24{signed_q & mem_din[7]}}, mem_din};
                        3'd2:    bus.resp_rdata = {{16{signed_q & mem_din[7]}}, mem_din, rbuf_q[7:0]};
                        default: bus.resp_rdata = {mem_din, rbuf_q};
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule
